// File: rtl/regfile_wport_sched.sv
// Arbitrates the single register-file write port between WB and a queued long-latency
// result stream, and tracks outstanding long-op destinations to stall ID.
module regfile_wport_sched #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RegWrite_wb,
  input  logic [AW-1:0] RegWriteAddr_wb,
  input  logic [DW-1:0] RegWriteData_wb,
  input  logic          Lop_valid,
  output logic          Lop_ready,
  input  logic [AW-1:0] Lop_addr,
  input  logic [DW-1:0] Lop_data,
  input  logic          Issue_id,
  input  logic [AW-1:0] IssueAddr_id,
  input  logic          DestWrite_id,
  input  logic [AW-1:0] DestAddr_id,
  input  logic [AW-1:0] RsAddr_id,
  input  logic [AW-1:0] RtAddr_id,
  output logic          RegWrite,
  output logic [AW-1:0] WriteAddr,
  output logic [DW-1:0] WriteData,
  output logic          Sched_stall,
  output logic [AW:0]   Pending
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 1 << AW;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0] q_addr [QDEPTH];
  logic [DW-1:0] q_data [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ready_q;
  logic [NR-1:0] busy, busy_nxt;
  logic [SW-1:0] starve;
  logic [AW:0]   pending_q, pending_nxt;
  logic          empty, full, push, pop, starved;

  assign empty = (count == '0);
  assign full  = (count == CW'(QDEPTH));
  assign pop   = !RegWrite_wb && !empty;
  // A full queue still accepts when the head leaves in the same cycle.
  assign Lop_ready = ready_q && (!full || pop);
  assign push  = Lop_valid && Lop_ready;

  always_comb begin
    RegWrite  = 1'b0;
    WriteAddr = '0;
    WriteData = '0;
    if (RegWrite_wb) begin
      RegWrite  = 1'b1;
      WriteAddr = RegWriteAddr_wb;
      WriteData = RegWriteData_wb;
    end else if (!empty) begin
      RegWrite  = 1'b1;
      WriteAddr = q_addr[rd_ptr];
      WriteData = q_data[rd_ptr];
    end
  end

  always_comb begin
    busy_nxt = busy;
    if (pop && q_addr[rd_ptr] != '0)
      busy_nxt[q_addr[rd_ptr]] = 1'b0;
    if (Issue_id && IssueAddr_id != '0)
      busy_nxt[IssueAddr_id] = 1'b1;
    pending_nxt = '0;
    for (int unsigned i = 0; i < NR; i++)
      pending_nxt = pending_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_q   <= 1'b0;
      busy      <= '0;
      starve    <= '0;
      pending_q <= '0;
    end else begin
      ready_q   <= 1'b1;
      busy      <= busy_nxt;
      pending_q <= pending_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (empty || pop)
        starve <= '0;
      else if (RegWrite_wb && !starved)
        starve <= starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= Lop_addr;
      q_data[wr_ptr] <= Lop_data;
    end
  end

  assign starved = (starve == SW'(STARVE_MAX));
  assign Pending = pending_q;

  assign Sched_stall = (RsAddr_id    != '0 && busy[RsAddr_id])
                     | (RtAddr_id    != '0 && busy[RtAddr_id])
                     | (DestWrite_id && DestAddr_id  != '0 && busy[DestAddr_id])
                     | (Issue_id     && IssueAddr_id != '0 && busy[IssueAddr_id])
                     | starved;

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Directed scenarios for regfile_wport_sched with hand-computed expectations.
module tb_regfile_wport_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] RegWriteData_wb;
  logic        Lop_valid;
  logic        Lop_ready;
  logic [4:0]  Lop_addr;
  logic [31:0] Lop_data;
  logic        Issue_id;
  logic [4:0]  IssueAddr_id;
  logic        DestWrite_id;
  logic [4:0]  DestAddr_id;
  logic [4:0]  RsAddr_id;
  logic [4:0]  RtAddr_id;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        Sched_stall;
  logic [5:0]  Pending;

  int checks = 0;
  int failures = 0;

  regfile_wport_sched #(.DW(32), .AW(5), .QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb),
    .Lop_valid(Lop_valid), .Lop_ready(Lop_ready), .Lop_addr(Lop_addr), .Lop_data(Lop_data),
    .Issue_id(Issue_id), .IssueAddr_id(IssueAddr_id),
    .DestWrite_id(DestWrite_id), .DestAddr_id(DestAddr_id),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .Sched_stall(Sched_stall), .Pending(Pending)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    RegWrite_wb = 0; RegWriteAddr_wb = 0; RegWriteData_wb = 0;
    Lop_valid = 0; Lop_addr = 0; Lop_data = 0;
    Issue_id = 0; IssueAddr_id = 0; DestWrite_id = 0; DestAddr_id = 0;
    RsAddr_id = 0; RtAddr_id = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    checks++; if (Lop_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b exp=0", Lop_ready); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (Lop_ready !== 1'b1) begin failures++; $display("FAIL post_release_ready got=%b exp=1", Lop_ready); end
    RegWrite_wb = 1; RegWriteAddr_wb = 1; RegWriteData_wb = 32'h11;
    Lop_valid = 1; Lop_addr = 11; Lop_data = 32'hB;
    tick();
    Lop_addr = 12; Lop_data = 32'hC;
    tick();
    #1;
    checks++; if (Lop_ready !== 1'b0) begin failures++; $display("FAIL full_before_reset got=%b exp=0", Lop_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (Lop_ready !== 1'b0) begin failures++; $display("FAIL ready_in_reset got=%b exp=0", Lop_ready); end
    checks++; if (Pending !== 6'd0) begin failures++; $display("FAIL pending_in_reset got=%0d exp=0", Pending); end
    idle_inputs();
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL regwrite_in_reset got=%b exp=0", RegWrite); end
    checks++; if (Sched_stall !== 1'b0) begin failures++; $display("FAIL stall_in_reset got=%b exp=0", Sched_stall); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (Lop_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", Lop_ready); end
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL queue_flushed got=%b exp=0", RegWrite); end
  endtask

  task automatic test_issue_and_return();
    idle_inputs();
    Issue_id = 1; IssueAddr_id = 5;
    tick();
    Issue_id = 0; IssueAddr_id = 0; RsAddr_id = 5;
    Lop_valid = 1; Lop_addr = 5; Lop_data = 32'h1234;
    #1;
    checks++; if (Sched_stall !== 1'b1) begin failures++; $display("FAIL rs_busy_stall got=%b exp=1", Sched_stall); end
    checks++; if (Pending !== 6'd1) begin failures++; $display("FAIL pending_after_issue got=%0d exp=1", Pending); end
    tick();
    Lop_valid = 0;
    #1;
    checks++; if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd5, 32'h1234}) begin
      failures++; $display("FAIL lop_write got=%b/%0d/%h exp=1/5/1234", RegWrite, WriteAddr, WriteData); end
    checks++; if (Sched_stall !== 1'b1) begin failures++; $display("FAIL stall_during_write got=%b exp=1", Sched_stall); end
    tick();
    checks++; if (Sched_stall !== 1'b0) begin failures++; $display("FAIL stall_cleared got=%b exp=0", Sched_stall); end
    checks++; if (Pending !== 6'd0) begin failures++; $display("FAIL pending_cleared got=%0d exp=0", Pending); end
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL port_idle got=%b exp=0", RegWrite); end
  endtask

  task automatic test_starvation();
    idle_inputs();
    RegWrite_wb = 1; RegWriteAddr_wb = 3; RegWriteData_wb = 32'h33;
    Lop_valid = 1; Lop_addr = 7; Lop_data = 32'h77;
    tick();
    Lop_valid = 0;
    #1;
    checks++; if (WriteAddr !== 5'd3 || WriteData !== 32'h33) begin
      failures++; $display("FAIL wb_wins got=%0d/%h exp=3/33", WriteAddr, WriteData); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (Sched_stall !== 1'b0) begin failures++; $display("FAIL early_starve_stall cycle=%0d got=%b exp=0", i, Sched_stall); end
      tick();
    end
    checks++; if (Sched_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%b exp=1", Sched_stall); end
    RegWrite_wb = 0;
    #1;
    checks++; if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd7, 32'h77}) begin
      failures++; $display("FAIL bubble_drain got=%b/%0d/%h exp=1/7/77", RegWrite, WriteAddr, WriteData); end
    checks++; if (Sched_stall !== 1'b1) begin failures++; $display("FAIL starve_hold got=%b exp=1", Sched_stall); end
    tick();
    checks++; if (Sched_stall !== 1'b0) begin failures++; $display("FAIL starve_release got=%b exp=0", Sched_stall); end
  endtask

  task automatic test_full_queue();
    idle_inputs();
    RegWrite_wb = 1; RegWriteAddr_wb = 1; RegWriteData_wb = 32'h1;
    Lop_valid = 1; Lop_addr = 8; Lop_data = 32'h88;
    tick();
    Lop_addr = 9; Lop_data = 32'h99;
    tick();
    Lop_addr = 10; Lop_data = 32'hAA;
    #1;
    checks++; if (Lop_ready !== 1'b0) begin failures++; $display("FAIL full_not_ready got=%b exp=0", Lop_ready); end
    tick();
    checks++; if (Lop_ready !== 1'b0) begin failures++; $display("FAIL held_not_ready got=%b exp=0", Lop_ready); end
    RegWrite_wb = 0;
    #1;
    checks++; if (Lop_ready !== 1'b1 || WriteAddr !== 5'd8) begin
      failures++; $display("FAIL pop_push_accept got=%b/%0d exp=1/8", Lop_ready, WriteAddr); end
    tick();
    Lop_valid = 0; RegWrite_wb = 1;
    #1;
    checks++; if (Lop_ready !== 1'b0) begin failures++; $display("FAIL count_stays_two got=%b exp=0", Lop_ready); end
    RegWrite_wb = 0;
    #1;
    checks++; if (WriteAddr !== 5'd9 || WriteData !== 32'h99) begin
      failures++; $display("FAIL order_r9 got=%0d/%h exp=9/99", WriteAddr, WriteData); end
    tick();
    checks++; if (WriteAddr !== 5'd10 || WriteData !== 32'hAA) begin
      failures++; $display("FAIL order_r10 got=%0d/%h exp=10/aa", WriteAddr, WriteData); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL drained got=%b exp=0", RegWrite); end
  endtask

  task automatic test_waw_and_r0();
    idle_inputs();
    Issue_id = 1; IssueAddr_id = 4;
    tick();
    Issue_id = 0; IssueAddr_id = 0; DestWrite_id = 1; DestAddr_id = 4;
    #1;
    checks++; if (Sched_stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", Sched_stall); end
    DestWrite_id = 0;
    #1;
    checks++; if (Sched_stall !== 1'b0) begin failures++; $display("FAIL dest_unqualified got=%b exp=0", Sched_stall); end
    Issue_id = 1; IssueAddr_id = 0;
    #1;
    checks++; if (Sched_stall !== 1'b0) begin failures++; $display("FAIL issue_r0_stall got=%b exp=0", Sched_stall); end
    tick();
    Issue_id = 0;
    checks++; if (Pending !== 6'd1) begin failures++; $display("FAIL r0_not_busy got=%0d exp=1", Pending); end
    Lop_valid = 1; Lop_addr = 4; Lop_data = 32'h44;
    tick();
    Lop_valid = 0;
    tick();
    checks++; if (Pending !== 6'd0) begin failures++; $display("FAIL r4_cleared got=%0d exp=0", Pending); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    Issue_id = 1; IssueAddr_id = 6;
    tick();
    Issue_id = 0; IssueAddr_id = 0;
    RegWrite_wb = 1; RegWriteAddr_wb = 2; RegWriteData_wb = 32'h22;
    Lop_valid = 1; Lop_addr = 6; Lop_data = 32'h66;
    #1;
    checks++; if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd2, 32'h22}) begin
      failures++; $display("FAIL simul_wb got=%b/%0d/%h exp=1/2/22", RegWrite, WriteAddr, WriteData); end
    checks++; if (Pending !== 6'd1) begin failures++; $display("FAIL simul_pending1 got=%0d exp=1", Pending); end
    tick();
    RegWrite_wb = 0; Lop_valid = 0;
    #1;
    checks++; if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd6, 32'h66}) begin
      failures++; $display("FAIL simul_lop got=%b/%0d/%h exp=1/6/66", RegWrite, WriteAddr, WriteData); end
    tick();
    checks++; if (Pending !== 6'd0) begin failures++; $display("FAIL simul_pending0 got=%0d exp=0", Pending); end
  endtask

  initial begin
    test_reset();
    test_issue_and_return();
    test_starvation();
    test_full_queue();
    test_waw_and_r0();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
